prog_sequencer: RTL and testbench

- Control FSM that sequences the 8-entry program ROM and the register-file/ALU datapath.
- Owns the program counter and drives the ROM address; the ROM is combinational.
- Latches each 16-bit instruction and decodes it into register-file and ALU strobes.
- Handles the OUT handshake towards the display/output stage, and halts or wraps at end of program.

---
 rtl/proc_pkg.sv | 37 +++
 rtl/instr_decode.sv | 41 ++++
 rtl/prog_sequencer.sv | 134 +++++++++++++
 tb/tb_prog_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the program sequencer: opcode values, instruction
// field positions, FSM state encoding and decoded opcode classes.
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT,
    S_HALT,
    S_STEP_WAIT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_ADDI,
    C_ADD,
    C_JMP,
    C_OUT
  } op_class_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits the latched instruction into
// fields and classifies the opcode; unknown opcodes decode as NOP + illegal.
module instr_decode
  import proc_pkg::*;
(
  input  logic [15:0] ir,
  output op_class_t   op_class,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [8:0]  imm9,
  output logic        alu_b_sel,
  output logic        is_write,
  output logic        is_illegal
);

  logic [3:0] opcode;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign imm9   = ir[IMM_HI:IMM_LO];

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_class   = C_NOP;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:  op_class = C_NOP;
      OP_ADDI: op_class = C_ADDI;
      OP_ADD:  op_class = C_ADD;
      OP_JMP:  op_class = C_JMP;
      OP_OUT:  op_class = C_OUT;
      default: is_illegal = 1'b1;
    endcase
  end

  assign alu_b_sel = (op_class == C_ADDI);
  assign is_write  = (op_class == C_ADDI) || (op_class == C_ADD);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer FSM: fetches from a combinational ROM, decodes into
// register-file/ALU strobes and runs the OUT handshake. SINGLE_STEP_EN adds a step input.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [2:0]        rf_raddr_a,
  output logic [2:0]        rf_raddr_b,
  output logic              alu_b_sel,
  output logic [8:0]        imm9,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef SINGLE_STEP_EN
  localparam state_t NEXT_FETCH = S_STEP_WAIT;
`else
  localparam state_t NEXT_FETCH = S_FETCH;
`endif

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;

  op_class_t         op_class;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic              is_write;
  logic              is_illegal;
  logic              at_end;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jmp_target;

  instr_decode u_decode (
    .ir         (ir),
    .op_class   (op_class),
    .rd         (rd),
    .rs         (rs),
    .imm9       (imm9),
    .alu_b_sel  (alu_b_sel),
    .is_write   (is_write),
    .is_illegal (is_illegal)
  );

  assign pc_inc     = pc + ADDR_W'(1);
  assign at_end     = !WRAP && (pc == LAST_ADDR);
  assign jmp_target = imm9[ADDR_W-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= rom_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_illegal) illegal <= 1'b1;
          if (op_class == C_JMP) begin
            pc    <= jmp_target;
            state <= NEXT_FETCH;
          end else if (op_class == C_OUT) begin
            state <= S_OUT_WAIT;
          end else if (at_end) begin
            pc    <= '0;
            state <= S_HALT;
          end else begin
            pc    <= pc_inc;
            state <= NEXT_FETCH;
          end
        end
        S_OUT_WAIT: begin
          // pc stays on the OUT instruction until the output stage accepts
          if (out_ready) begin
            if (at_end) begin
              pc    <= '0;
              state <= S_HALT;
            end else begin
              pc    <= pc_inc;
              state <= NEXT_FETCH;
            end
          end
        end
`ifdef SINGLE_STEP_EN
        S_STEP_WAIT: begin
          if (step) state <= S_FETCH;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status strobes decode the state register only, never rom_data.
  assign rom_addr   = pc;
  assign rf_we      = (state == S_EXEC) && is_write;
  assign rf_waddr   = rd;
  assign rf_raddr_a = rd;
  assign rf_raddr_b = rs;
  assign out_valid  = (state == S_OUT_WAIT);
  assign halted     = (state == S_HALT);
  assign busy       = (state == S_FETCH) || (state == S_EXEC) ||
                      (state == S_OUT_WAIT) || (state == S_STEP_WAIT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: one WRAP=0 instance with a writable ROM
// and one WRAP=1 instance fed an all-NOP ROM.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start0 = 1'b0;
  logic        out_ready0 = 1'b1;
  logic [2:0]  rom_addr0;
  logic [15:0] rom_data0;
  logic        rf_we0, alu_b_sel0, out_valid0, busy0, halted0, illegal0;
  logic [2:0]  rf_waddr0, rf_raddr_a0, rf_raddr_b0;
  logic [8:0]  imm90;
  logic [15:0] rom0 [8];

  logic        start1 = 1'b0;
  logic [2:0]  rom_addr1;
  logic        rf_we1, alu_b_sel1, out_valid1, busy1, halted1, illegal1;
  logic [2:0]  rf_waddr1, rf_raddr_a1, rf_raddr_b1;
  logic [8:0]  imm91;

`ifdef SINGLE_STEP_EN
  logic        step0 = 1'b0;
  logic        step1 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_data0 = rom0[rom_addr0];

  prog_sequencer #(.ADDR_W(3), .WRAP(1'b0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start0),
`ifdef SINGLE_STEP_EN
    .step       (step0),
`endif
    .rom_addr   (rom_addr0),
    .rom_data   (rom_data0),
    .rf_we      (rf_we0),
    .rf_waddr   (rf_waddr0),
    .rf_raddr_a (rf_raddr_a0),
    .rf_raddr_b (rf_raddr_b0),
    .alu_b_sel  (alu_b_sel0),
    .imm9       (imm90),
    .out_valid  (out_valid0),
    .out_ready  (out_ready0),
    .busy       (busy0),
    .halted     (halted0),
    .illegal    (illegal0)
  );

  prog_sequencer #(.ADDR_W(3), .WRAP(1'b1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
`ifdef SINGLE_STEP_EN
    .step       (step1),
`endif
    .rom_addr   (rom_addr1),
    .rom_data   (16'h0000),
    .rf_we      (rf_we1),
    .rf_waddr   (rf_waddr1),
    .rf_raddr_a (rf_raddr_a1),
    .rf_raddr_b (rf_raddr_b1),
    .alu_b_sel  (alu_b_sel1),
    .imm9       (imm91),
    .out_valid  (out_valid1),
    .out_ready  (1'b1),
    .busy       (busy1),
    .halted     (halted1),
    .illegal    (illegal1)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ADDI r1,32 / ADDI r2,10 / ADD r1,r2 / five OUT r1
  task automatic load_stock();
    rom0[0] = 16'h1220;
    rom0[1] = 16'h140A;
    rom0[2] = 16'h2280;
    for (int i = 3; i < 8; i++) rom0[i] = 16'hF200;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the sample point of cycle 1 (first FETCH).
  task automatic start_prog0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({rom_addr0, rf_we0, out_valid0, busy0, halted0, illegal0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {rom_addr0, rf_we0, out_valid0, busy0, halted0, illegal0}, 8'h00);
    end
    checks++;
    if ({rf_waddr0, imm90} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ir: got %h expected 000", {rf_waddr0, imm90});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, halted0, rom_addr0} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_idle_hold: got %b expected 00000", {busy0, halted0, rom_addr0});
    end
  endtask

  task automatic test_stock_program();
    int we_cnt = 0;
    int ov_cnt = 0;
    int bad_a = 0;
    int halt_cyc = -1;
    load_stock();
    out_ready0 = 1'b1;
    do_reset();
    start_prog0();
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge clk);
      if (rf_we0) we_cnt++;
      if (out_valid0) begin
        ov_cnt++;
        if (rf_raddr_a0 !== 3'd1) bad_a++;
      end
      if (halted0 && halt_cyc < 0) halt_cyc = c;
      if (c == 2) begin
        checks++;
        if ({rf_we0, rf_waddr0, imm90, alu_b_sel0} !== {1'b1, 3'd1, 9'd32, 1'b1}) begin
          errors++;
          $display("FAIL stock_addi1: got %h expected %h",
                   {rf_we0, rf_waddr0, imm90, alu_b_sel0}, {1'b1, 3'd1, 9'd32, 1'b1});
        end
      end
      if (c == 4) begin
        checks++;
        if ({rf_we0, rf_waddr0, imm90, alu_b_sel0} !== {1'b1, 3'd2, 9'd10, 1'b1}) begin
          errors++;
          $display("FAIL stock_addi2: got %h expected %h",
                   {rf_we0, rf_waddr0, imm90, alu_b_sel0}, {1'b1, 3'd2, 9'd10, 1'b1});
        end
      end
      if (c == 6) begin
        checks++;
        if ({rf_we0, rf_waddr0, rf_raddr_b0, alu_b_sel0} !== {1'b1, 3'd1, 3'd2, 1'b0}) begin
          errors++;
          $display("FAIL stock_add: got %b expected %b",
                   {rf_we0, rf_waddr0, rf_raddr_b0, alu_b_sel0}, {1'b1, 3'd1, 3'd2, 1'b0});
        end
      end
    end
    checks++;
    if (we_cnt != 3) begin
      errors++;
      $display("FAIL stock_we_count: got %0d expected 3", we_cnt);
    end
    checks++;
    if (ov_cnt != 5 || bad_a != 0) begin
      errors++;
      $display("FAIL stock_out_pulses: got %0d (bad raddr_a %0d) expected 5 (0)", ov_cnt, bad_a);
    end
    checks++;
    if (halt_cyc != 22) begin
      errors++;
      $display("FAIL stock_halt_cycle: got %0d expected 22", halt_cyc);
    end
    checks++;
    if ({halted0, busy0, rom_addr0} !== 5'b10000) begin
      errors++;
      $display("FAIL stock_halt_hold: got %b expected 10000", {halted0, busy0, rom_addr0});
    end
  endtask

  task automatic test_out_stall();
    int bad = 0;
    int accepts = 0;
    load_stock();
    out_ready0 = 1'b0;
    do_reset();
    start_prog0();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (!out_valid0 || rom_addr0 !== 3'd3 || rf_we0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    out_ready0 = 1'b1;
    if (out_valid0) accepts++;
    @(negedge clk);
    out_ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid0 && out_ready0) accepts++;
      if (i == 0) begin
        checks++;
        if ({out_valid0, rom_addr0} !== 4'b0100) begin
          errors++;
          $display("FAIL stall_release_addr: got %b expected 0100", {out_valid0, rom_addr0});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (accepts != 1) begin
      errors++;
      $display("FAIL stall_accepts: got %0d expected 1", accepts);
    end
    out_ready0 = 1'b1;
  endtask

  task automatic test_illegal_jmp();
    int we_cnt = 0;
    for (int i = 0; i < 8; i++) rom0[i] = 16'h0000;
    rom0[1] = 16'h7000;
    rom0[2] = 16'h3005;
    out_ready0 = 1'b1;
    do_reset();
    start_prog0();
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if (rf_we0) we_cnt++;
      if (c == 4) begin
        checks++;
        if ({illegal0, rom_addr0} !== 4'b0001) begin
          errors++;
          $display("FAIL illegal_before: got %b expected 0001", {illegal0, rom_addr0});
        end
      end
      if (c == 5) begin
        checks++;
        if ({illegal0, rom_addr0} !== 4'b1010) begin
          errors++;
          $display("FAIL illegal_rise: got %b expected 1010", {illegal0, rom_addr0});
        end
      end
      if (c == 7) begin
        checks++;
        if (rom_addr0 !== 3'd5) begin
          errors++;
          $display("FAIL jmp_target: got %0d expected 5", rom_addr0);
        end
      end
      if (c == 13) begin
        checks++;
        if (halted0 !== 1'b1) begin
          errors++;
          $display("FAIL jmp_then_halt: got %b expected 1", halted0);
        end
      end
    end
    checks++;
    if ({illegal0, we_cnt[3:0]} !== 5'b10000) begin
      errors++;
      $display("FAIL illegal_sticky: got illegal=%b we=%0d expected 1 0", illegal0, we_cnt);
    end
  endtask

  task automatic test_reset_in_out_wait();
    load_stock();
    out_ready0 = 1'b0;
    do_reset();
    start_prog0();
    repeat (9) @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_out_valid: got %b expected 1", out_valid0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, busy0, illegal0} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async_drop: got %b expected 000", {out_valid0, busy0, illegal0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy0, halted0, out_valid0, rom_addr0} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_idle: got %b expected 000000", {busy0, halted0, out_valid0, rom_addr0});
    end
    start_prog0();
    checks++;
    if ({busy0, rom_addr0} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_restart_fetch: got %b expected 1000", {busy0, rom_addr0});
    end
    @(negedge clk);
    checks++;
    if ({rf_we0, rf_waddr0, imm90} !== {1'b1, 3'd1, 9'd32}) begin
      errors++;
      $display("FAIL rst_restart_exec: got %h expected %h",
               {rf_we0, rf_waddr0, imm90}, {1'b1, 3'd1, 9'd32});
    end
  endtask

  task automatic test_wrap();
    int bad_seq = 0;
    int halt_seen = 0;
    int idle_seen = 0;
    logic [2:0] exp_addr;
    do_reset();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (halted1) halt_seen++;
      if (!busy1) idle_seen++;
      if ((c % 2) == 1 && c <= 19) begin
        exp_addr = 3'((c - 1) / 2);
        if (rom_addr1 !== exp_addr) bad_seq++;
      end
      if (c == 17) begin
        checks++;
        if (rom_addr1 !== 3'd0) begin
          errors++;
          $display("FAIL wrap_to_zero: got %0d expected 0", rom_addr1);
        end
      end
    end
    checks++;
    if (bad_seq != 0) begin
      errors++;
      $display("FAIL wrap_sequence: got %0d bad steps expected 0", bad_seq);
    end
    checks++;
    if (halt_seen != 0 || idle_seen != 0) begin
      errors++;
      $display("FAIL wrap_no_halt: got halted %0d idle %0d expected 0 0", halt_seen, idle_seen);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int bad = 0;
    load_stock();
    out_ready0 = 1'b1;
    step0 = 1'b0;
    do_reset();
    start_prog0();
    @(negedge clk);
    checks++;
    if ({rf_we0, rf_waddr0} !== 4'b1001) begin
      errors++;
      $display("FAIL step_first_exec: got %b expected 1001", {rf_we0, rf_waddr0});
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (rom_addr0 !== 3'd1 || rf_we0 || !busy0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL step_hold: got %0d bad cycles expected 0", bad);
    end
    step0 = 1'b1;
    @(negedge clk);
    step0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_we0, rf_waddr0, imm90} !== {1'b1, 3'd2, 9'd10}) begin
      errors++;
      $display("FAIL step_second_exec: got %h expected %h",
               {rf_we0, rf_waddr0, imm90}, {1'b1, 3'd2, 9'd10});
    end
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rom_addr0 !== 3'd2 || rf_we0 || !busy0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL step_hold2: got %0d bad cycles expected 0", bad);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) rom0[i] = 16'h0000;
    test_reset();
`ifdef SINGLE_STEP_EN
    test_single_step();
    test_reset_in_out_wait();
`else
    test_stock_program();
    test_out_stall();
    test_illegal_jmp();
    test_reset_in_out_wait();
    test_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
